// File: rtl/t09_edge_detector_array.sv
// Input conditioner: per-channel synchroniser, debounce, mode-selected edge pulse and sticky flag.
// Latency: sig_i sampled at E0 -> level/pulse change after edge E0+SYNC_STAGES+DEB_CNT-1; flag one edge later.
// Backpressure: none; free-running every cycle, pulses are one cycle wide and latched into flags.
module t09_edge_detector_array #(
  parameter int WIDTH       = 7,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT     = 4,
  parameter int CNT_W       = $clog2(DEB_CNT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     sig_i,
  input  logic [2*WIDTH-1:0]   mode_i,
  input  logic [WIDTH-1:0]     clr_i,
  output logic [WIDTH-1:0]     level_o,
  output logic [WIDTH-1:0]     pulse_o,
  output logic [WIDTH-1:0]     flag_o,
  output logic                 any_o
);

  // Count value at which a persisting new level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_w;
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] flag_q, flag_d;
  logic [WIDTH-1:0] rise_w, fall_w, pulse_w;

  // Synchroniser chain; stage 0 captures the raw asynchronous pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= sig_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // Debounce: a differing synchronised value must persist DEB_CNT cycles before it is accepted.
  always_comb begin
    stable_d = stable_q;
    for (int n = 0; n < WIDTH; n++) begin
      cnt_d[n] = '0;
      if (sync_w[n] != stable_q[n]) begin
        if (cnt_q[n] == CNT_LAST) begin
          stable_d[n] = sync_w[n];
          cnt_d[n]    = '0;
        end else begin
          cnt_d[n] = cnt_q[n] + CNT_W'(1);
        end
      end
    end
  end

  // Edge terms gated by the per-channel mode: bit 0 enables rise, bit 1 enables fall.
  always_comb begin
    rise_w  = stable_q & ~prev_q;
    fall_w  = ~stable_q & prev_q;
    pulse_w = '0;
    for (int n = 0; n < WIDTH; n++) begin
      pulse_w[n] = (mode_i[2*n] & rise_w[n]) | (mode_i[2*n+1] & fall_w[n]);
    end
  end

  // Sticky flags: a pulse sets, a clear resets, and a coincident pulse beats the clear.
  always_comb begin
    flag_d = pulse_w | (flag_q & ~clr_i);
  end

  // Debounce state, edge history and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= '0;
      end
      stable_q <= '0;
      prev_q   <= '0;
      flag_q   <= '0;
    end else begin
      for (int n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
      stable_q <= stable_d;
      prev_q   <= stable_q;
      flag_q   <= flag_d;
    end
  end

  assign level_o = stable_q;
  assign pulse_o = pulse_w;
  assign flag_o  = flag_q;
  assign any_o   = |flag_q;

endmodule

// File: tb/tb_t09_edge_detector_array.sv
// Bench for the edge detector array: default build plus a WIDTH=2/SYNC=1/DEB=1 build.
// Latency: expectations are tagged with the absolute cycle in which they must hold.
// Backpressure: not applicable; the monitor checks every cycle on the falling edge.
module tb_t09_edge_detector_array;

  logic        clk;
  logic        rst;
  logic [6:0]  sig_i;
  logic [13:0] mode_i;
  logic [6:0]  clr_i;
  logic [6:0]  level_o, pulse_o, flag_o;
  logic        any_o;

  logic [1:0]  sig2, clr2, level2, pulse2, flag2;
  logic [3:0]  mode2;
  logic        any2;

  t09_edge_detector_array u_dut (
    .clk(clk), .rst(rst), .sig_i(sig_i), .mode_i(mode_i), .clr_i(clr_i),
    .level_o(level_o), .pulse_o(pulse_o), .flag_o(flag_o), .any_o(any_o)
  );

  t09_edge_detector_array #(.WIDTH(2), .SYNC_STAGES(1), .DEB_CNT(1)) u_small (
    .clk(clk), .rst(rst), .sig_i(sig2), .mode_i(mode2), .clr_i(clr2),
    .level_o(level2), .pulse_o(pulse2), .flag_o(flag2), .any_o(any2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // sel: 0 level, 1 pulse, 2 flag, 3 any, 4 small level, 5 small pulse, 6 small flag, 7 small any
  typedef struct {
    int         at;
    int         sel;
    logic [6:0] mask;
    logic [6:0] val;
    string      name;
  } chk_t;

  chk_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input int at, input int sel, input logic [6:0] mask,
                     input logic [6:0] val, input string name);
    chk_t e;
    e.at = at; e.sel = sel; e.mask = mask; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic chk_zero(input int at, input string name);
    chk(at, 0, 7'h7F, 7'h00, {name, "_level"});
    chk(at, 1, 7'h7F, 7'h00, {name, "_pulse"});
    chk(at, 2, 7'h7F, 7'h00, {name, "_flag"});
    chk(at, 3, 7'h01, 7'h00, {name, "_any"});
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [6:0] pick(input int sel);
    case (sel)
      0:       return level_o;
      1:       return pulse_o;
      2:       return flag_o;
      3:       return {6'b0, any_o};
      4:       return {5'b0, level2};
      5:       return {5'b0, pulse2};
      6:       return {5'b0, flag2};
      default: return {6'b0, any2};
    endcase
  endfunction

  chk_t       mon_e;
  logic [6:0] mon_act;

  // Monitor: on each falling edge, retire every expectation due in this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        mon_e   = sb[i];
        mon_act = pick(mon_e.sel) & mon_e.mask;
        n_cmp++;
        if (mon_e.at < cyc) begin
          n_fail++;
          $display("FAIL %s: expectation for cycle %0d missed (now %0d)", mon_e.name, mon_e.at, cyc);
        end else if (mon_act !== mon_e.val) begin
          n_fail++;
          $display("FAIL %s @cycle %0d: got %b expected %b (mask %b)",
                   mon_e.name, cyc, mon_act, mon_e.val, mon_e.mask);
        end
        sb.delete(i);
      end
    end
  end

  int c;

  initial begin
    rst    = 1'b1;
    sig_i  = '0;
    mode_i = '0;
    clr_i  = '0;
    sig2   = '0;
    mode2  = 4'hF;
    clr2   = '0;

    // Reset state, during reset and in the first cycle after release.
    ticks(2);
    c = cyc;
    chk_zero(c, "rst_hold");
    chk(c, 4, 7'h03, 7'h00, "rst_small_level");
    chk(c, 6, 7'h03, 7'h00, "rst_small_flag");
    ticks(1);
    rst = 1'b0;
    c = cyc;
    chk_zero(c, "rst_rel0");
    chk_zero(c + 1, "rst_rel1");
    ticks(3);

    // 1: rise on ch4 with mode 01 everywhere.
    mode_i = 14'h1555;
    ticks(1);
    c = cyc;
    sig_i[4] = 1'b1;
    chk(c + 5, 0, 7'h10, 7'h00, "t1_level_early");
    chk(c + 5, 1, 7'h7F, 7'h00, "t1_pulse_early");
    chk(c + 6, 0, 7'h7F, 7'h10, "t1_level");
    chk(c + 6, 1, 7'h7F, 7'h10, "t1_pulse");
    chk(c + 6, 2, 7'h7F, 7'h00, "t1_flag_early");
    chk(c + 7, 1, 7'h7F, 7'h00, "t1_pulse_width");
    chk(c + 7, 2, 7'h7F, 7'h10, "t1_flag");
    chk(c + 7, 3, 7'h01, 7'h01, "t1_any");
    ticks(10);

    // 2: three-cycle glitch on ch6, all modes both-edge.
    mode_i = 14'h3FFF;
    ticks(1);
    c = cyc;
    sig_i[6] = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      chk(c + k, 0, 7'h40, 7'h00, "t2_level");
      chk(c + k, 1, 7'h40, 7'h00, "t2_pulse");
      chk(c + k, 2, 7'h40, 7'h00, "t2_flag");
    end
    ticks(3);
    sig_i[6] = 1'b0;
    ticks(10);

    // 3: ch5 in fall-only mode; rise then fall, each held 10 cycles.
    mode_i = 14'h3BFF;
    ticks(1);
    c = cyc;
    sig_i[5] = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      chk(c + k, 1, 7'h20, 7'h00, "t3_no_rise_pulse");
    end
    chk(c + 6, 0, 7'h20, 7'h20, "t3_level_hi");
    chk(c + 15, 1, 7'h20, 7'h00, "t3_fall_early");
    chk(c + 16, 1, 7'h20, 7'h20, "t3_fall_pulse");
    chk(c + 16, 0, 7'h20, 7'h00, "t3_level_lo");
    chk(c + 16, 2, 7'h20, 7'h00, "t3_flag_early");
    chk(c + 17, 1, 7'h20, 7'h00, "t3_pulse_width");
    chk(c + 17, 2, 7'h20, 7'h20, "t3_flag");
    ticks(10);
    sig_i[5] = 1'b0;
    ticks(12);

    // 4: clear alone, then clear coinciding with a new ch4 pulse, then clear alone again.
    ticks(1);
    c = cyc;
    clr_i = 7'h7F;
    chk(c + 1, 2, 7'h7F, 7'h00, "t4_clr_all");
    chk(c + 1, 3, 7'h01, 7'h00, "t4_clr_any");
    ticks(1);
    clr_i    = 7'h00;
    sig_i[4] = 1'b0;
    chk(c + 7, 1, 7'h10, 7'h10, "t4_fall_pulse");
    ticks(6);
    clr_i[4] = 1'b1;
    chk(c + 8, 2, 7'h10, 7'h10, "t4_set_wins");
    chk(c + 8, 3, 7'h01, 7'h01, "t4_set_wins_any");
    ticks(1);
    clr_i = 7'h00;
    ticks(2);
    clr_i[4] = 1'b1;
    chk(c + 11, 2, 7'h7F, 7'h00, "t4_clr_alone");
    chk(c + 11, 3, 7'h01, 7'h00, "t4_clr_alone_any");
    ticks(1);
    clr_i = 7'h00;
    ticks(3);

    // 5: ch3..0 held high, reset pulsed mid-count, events after release.
    mode_i = 14'h1555;
    ticks(1);
    c = cyc;
    sig_i[3:0] = 4'hF;
    ticks(3);
    rst = 1'b1;
    chk_zero(c + 3, "t5_rst");
    ticks(1);
    rst = 1'b0;
    chk_zero(c + 4, "t5_rel0");
    chk_zero(c + 5, "t5_rel1");
    for (int k = 6; k <= 9; k++) begin
      chk(c + k, 1, 7'h7F, 7'h00, "t5_no_pulse");
    end
    chk(c + 9, 0, 7'h0F, 7'h00, "t5_level_early");
    chk(c + 10, 0, 7'h0F, 7'h0F, "t5_level");
    chk(c + 10, 1, 7'h7F, 7'h0F, "t5_pulse");
    chk(c + 11, 1, 7'h7F, 7'h00, "t5_pulse_width");
    chk(c + 11, 2, 7'h7F, 7'h0F, "t5_flag");
    chk(c + 11, 3, 7'h01, 7'h01, "t5_any");
    ticks(12);

    // 6: small build, one sync stage, no debounce delay.
    ticks(1);
    c = cyc;
    sig2 = 2'b01;
    chk(c + 1, 4, 7'h03, 7'h00, "t6_level_early");
    chk(c + 2, 4, 7'h03, 7'h01, "t6_level");
    chk(c + 2, 5, 7'h03, 7'h01, "t6_pulse");
    chk(c + 3, 5, 7'h03, 7'h00, "t6_pulse_width");
    chk(c + 3, 6, 7'h03, 7'h01, "t6_flag");
    ticks(3);
    sig2 = 2'b10;
    chk(c + 5, 4, 7'h03, 7'h02, "t6_level_swap");
    chk(c + 5, 5, 7'h03, 7'h03, "t6_pulse_both");
    chk(c + 6, 5, 7'h03, 7'h00, "t6_pulse_width2");
    chk(c + 6, 6, 7'h03, 7'h03, "t6_flag_both");
    chk(c + 6, 7, 7'h01, 7'h01, "t6_any");

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 50 && sb.size() != 0; k++) begin
      ticks(1);
    end
    while (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never checked", sb[0].name, sb[0].at);
      void'(sb.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
